// File: rtl/sim_reset_sequencer.sv
// Simulation run-control: synchronized held-off reset, HOLD/RUN/DRAIN/DONE sequencing,
// run-cycle counter, heartbeat and sticky done/timeout. Optional tracing: SIM_RESET_SEQ_DISPLAY_EN.
module sim_reset_sequencer #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned RST_HOLD     = 11,
  parameter int unsigned MAX_CYCLES   = 1000,
  parameter int unsigned HB_PERIOD    = 100,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic             stop_i,
  output logic             rst_out_n,
  output logic             run_o,
  output logic             hb_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic             done_o,
  output logic             timeout_o
);

  localparam int unsigned HoldW  = $clog2(RST_HOLD + 1);
  localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned HbW    = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;

  localparam logic [HoldW-1:0]  HoldLast  = HoldW'(RST_HOLD - 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [HbW-1:0]    HbLast    = HbW'(HB_PERIOD - 1);
  localparam logic [CNT_W-1:0]  CntLast   = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {StHold, StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                sync_rst_n;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic [DrainW-1:0]   drain_q, drain_d;
  logic [HbW-1:0]      hb_cnt_q, hb_cnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rst_out_q, rst_out_d;
  logic                run_q, run_d;
  logic                hb_q, hb_d;
  logic                done_q, done_d;
  logic                to_q, to_d;
  logic                cnt_sat, hb_wrap, timeout_hit;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_rst_n = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StHold;
      hold_q    <= '0;
      drain_q   <= '0;
      hb_cnt_q  <= '0;
      cnt_q     <= '0;
      rst_out_q <= 1'b0;
      run_q     <= 1'b0;
      hb_q      <= 1'b0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      drain_q   <= drain_d;
      hb_cnt_q  <= hb_cnt_d;
      cnt_q     <= cnt_d;
      rst_out_q <= rst_out_d;
      run_q     <= run_d;
      hb_q      <= hb_d;
      done_q    <= done_d;
      to_q      <= to_d;
    end
  end

  // hb_cnt_q tracks cnt_q modulo HB_PERIOD so no divider is needed
  assign cnt_sat     = &cnt_q;
  assign hb_wrap     = (hb_cnt_q == HbLast);
  assign timeout_hit = (cnt_q == CntLast);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    drain_d   = drain_q;
    hb_cnt_d  = hb_cnt_q;
    cnt_d     = cnt_q;
    rst_out_d = rst_out_q;
    run_d     = run_q;
    hb_d      = 1'b0;
    done_d    = done_q;
    to_d      = to_q;
    case (state_q)
      StHold: begin
        if (sync_rst_n) begin
          if (hold_q == HoldLast) begin
            state_d   = StRun;
            rst_out_d = 1'b1;
            run_d     = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      StRun: begin
        if (!cnt_sat) begin
          cnt_d    = cnt_q + 1'b1;
          hb_cnt_d = hb_wrap ? '0 : hb_cnt_q + 1'b1;
          hb_d     = hb_wrap;
        end else begin
          // saturated count is re-presented as the new count
          hb_d = (hb_cnt_q == '0);
        end
        if (stop_i || timeout_hit) begin
          run_d = 1'b0;
          to_d  = timeout_hit;
          if (DRAIN_CYCLES == 0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StDone: begin
      end
      default: state_d = StHold;
    endcase
  end

  assign rst_out_n   = rst_out_q;
  assign run_o       = run_q;
  assign hb_o        = hb_q;
  assign cycle_cnt_o = cnt_q;
  assign done_o      = done_q;
  assign timeout_o   = to_q;

`ifdef SIM_RESET_SEQ_DISPLAY_EN
  always_ff @(posedge clk_i) begin
    if (reset_n) begin
      if (state_d != state_q) begin
        $display("sim_reset_sequencer: %s -> %s at %0t cycle_cnt=%0d",
                 state_q.name(), state_d.name(), $time, cnt_d);
      end
      if (hb_d) begin
        $display("sim_reset_sequencer: heartbeat at %0t cycle_cnt=%0d", $time, cnt_d);
      end
      if (state_q == StRun && state_d != StRun) begin
        $display("sim_reset_sequencer: %s", timeout_hit ? "TIMEOUT" : "STOP");
      end
    end
  end
`else
  // default build: no run-time reporting
`endif

endmodule

// File: tb/tb_sim_reset_sequencer.sv
// Bench for sim_reset_sequencer: default instance plus a short no-drain instance, both
// checked every cycle against a behavioural model, with table-driven and hand-written runs.
module tb_sim_reset_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_n = 1'b0;
  logic        stop_i = 1'b0;
  logic        rst_a, run_a, hb_a, done_a, to_a;
  logic [31:0] cnt_a;
  logic        rst_b, run_b, hb_b, done_b, to_b;
  logic [31:0] cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  sim_reset_sequencer dut_a (
    .clk_i(clk_i), .reset_n(reset_n), .stop_i(stop_i), .rst_out_n(rst_a), .run_o(run_a),
    .hb_o(hb_a), .cycle_cnt_o(cnt_a), .done_o(done_a), .timeout_o(to_a)
  );

  sim_reset_sequencer #(
    .SYNC_STAGES(3), .RST_HOLD(3), .MAX_CYCLES(20), .HB_PERIOD(7), .DRAIN_CYCLES(0), .CNT_W(32)
  ) dut_b (
    .clk_i(clk_i), .reset_n(reset_n), .stop_i(stop_i), .rst_out_n(rst_b), .run_o(run_b),
    .hb_o(hb_b), .cycle_cnt_o(cnt_b), .done_o(done_b), .timeout_o(to_b)
  );

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int unsigned sync_n, hold_n, max_n, hb_n, drain_n;
  } prm_t;

  localparam int PHold = 0, PRun = 1, PDrain = 2, PDone = 3;

  typedef struct {
    int              phase;
    int unsigned     edges;   // edges seen since reset_n released
    longint unsigned cnt;
    bit              rst, run, hb, done, to;
    int unsigned     dleft;
  } mdl_t;

  prm_t pa = '{2, 11, 1000, 100, 4};
  prm_t pb = '{3, 3, 20, 7, 0};
  mdl_t ma, mb;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.phase = PHold; m.edges = 0; m.cnt = 0; m.dleft = 0;
    m.rst = 0; m.run = 0; m.hb = 0; m.done = 0; m.to = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, prm_t p, bit stop);
    mdl_t n = m;
    bit   tmo;
    n.hb = 0;
    if (n.edges < 32'hFFFF) n.edges++;
    case (m.phase)
      PHold: if (n.edges == p.sync_n + p.hold_n) begin
        n.phase = PRun; n.rst = 1; n.run = 1;
      end
      PRun: begin
        tmo   = (m.cnt == longint'(p.max_n) - 1);
        n.cnt = (m.cnt == 64'hFFFF_FFFF) ? m.cnt : m.cnt + 1;
        n.hb  = (n.cnt % p.hb_n == 0);
        if (stop || tmo) begin
          n.run = 0;
          n.to  = tmo;
          if (p.drain_n == 0) begin
            n.phase = PDone; n.done = 1;
          end else begin
            n.phase = PDrain; n.dleft = p.drain_n;
          end
        end
      end
      PDrain: begin
        n.dleft--;
        if (n.dleft == 0) begin
          n.phase = PDone; n.done = 1;
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("a.rst_out_n", {63'd0, rst_a}, {63'd0, ma.rst});
    chk("a.run_o", {63'd0, run_a}, {63'd0, ma.run});
    chk("a.hb_o", {63'd0, hb_a}, {63'd0, ma.hb});
    chk("a.cycle_cnt_o", {32'd0, cnt_a}, ma.cnt);
    chk("a.done_o", {63'd0, done_a}, {63'd0, ma.done});
    chk("a.timeout_o", {63'd0, to_a}, {63'd0, ma.to});
    chk("b.rst_out_n", {63'd0, rst_b}, {63'd0, mb.rst});
    chk("b.run_o", {63'd0, run_b}, {63'd0, mb.run});
    chk("b.hb_o", {63'd0, hb_b}, {63'd0, mb.hb});
    chk("b.cycle_cnt_o", {32'd0, cnt_b}, mb.cnt);
    chk("b.done_o", {63'd0, done_b}, {63'd0, mb.done});
    chk("b.timeout_o", {63'd0, to_b}, {63'd0, mb.to});
  endtask

  // one clock edge, model update, sample 1 time unit later
  task automatic tick();
    @(posedge clk_i);
    if (reset_n) begin
      ma = mdl_step(ma, pa, stop_i);
      mb = mdl_step(mb, pb, stop_i);
    end
    #1;
    compare_all();
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    #1;
    ma = mdl_reset();
    mb = mdl_reset();
    compare_all();
  endtask

  // ---------------- table of full runs on the default instance ----------------
  typedef struct {
    int          stop_at;     // cycle_cnt_o value at which stop_i is pulsed, -1 for none
    int unsigned exp_cnt;
    bit          exp_to;
    int unsigned exp_hb;
    int unsigned exp_lag;     // edges from RUN exit to done_o
  } vec_t;

  vec_t vecs[4];

  initial begin
    int guard, hbs, lag;
    vecs[0] = '{-1, 1000, 1'b1, 10, 4};
    vecs[1] = '{250, 251, 1'b0, 2, 4};
    vecs[2] = '{999, 1000, 1'b1, 10, 4};
    vecs[3] = '{0, 1, 1'b0, 0, 4};
    ma = mdl_reset();
    mb = mdl_reset();

    // reset release latency
    #2;
    assert_reset();
    repeat (5) tick();
    reset_n = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      chk($sformatf("rel.rst_out_n@%0d", i), {63'd0, rst_a}, {63'd0, (i == 13)});
      chk($sformatf("rel.run_o@%0d", i), {63'd0, run_a}, {63'd0, (i == 13)});
      chk("rel.cycle_cnt_o", {32'd0, cnt_a}, 64'd0);
    end

    // no-drain instance: done_o rises on the same edge run_o falls
    guard = 0;
    while (!(rst_b && !run_b) && guard < 100) begin
      tick();
      guard++;
    end
    chk("nodrain.done_o", {63'd0, done_b}, 64'd1);
    chk("nodrain.cycle_cnt_o", {32'd0, cnt_b}, 64'd20);
    chk("nodrain.timeout_o", {63'd0, to_b}, 64'd1);

    foreach (vecs[k]) begin
      assert_reset();
      repeat (3) tick();
      reset_n = 1'b1;
      guard = 0;
      while (!run_a && guard < 40) begin
        tick();
        guard++;
      end
      chk($sformatf("vec%0d.run_rise", k), {63'd0, run_a}, 64'd1);
      hbs = 0;
      guard = 0;
      do begin
        stop_i = (vecs[k].stop_at >= 0) && (cnt_a == 32'(vecs[k].stop_at));
        tick();
        stop_i = 1'b0;
        hbs += int'(hb_a);
        guard++;
      end while (run_a && guard < 1100);
      chk($sformatf("vec%0d.cnt", k), {32'd0, cnt_a}, 64'(vecs[k].exp_cnt));
      chk($sformatf("vec%0d.timeout", k), {63'd0, to_a}, {63'd0, vecs[k].exp_to});
      chk($sformatf("vec%0d.hb_pulses", k), 64'(hbs), 64'(vecs[k].exp_hb));
      lag = 0;
      while (!done_a && lag < 10) begin
        tick();
        lag++;
      end
      chk($sformatf("vec%0d.done_lag", k), 64'(lag), 64'(vecs[k].exp_lag));
      stop_i = 1'b1;
      repeat (3) tick();
      stop_i = 1'b0;
      chk($sformatf("vec%0d.done_hold_cnt", k), {32'd0, cnt_a}, 64'(vecs[k].exp_cnt));
      chk($sformatf("vec%0d.done_sticky", k), {63'd0, done_a}, 64'd1);
    end

    // mid-run reset at count 500, stop pulses during HOLD ignored
    assert_reset();
    tick();
    reset_n = 1'b1;
    guard = 0;
    while (cnt_a != 32'd500 && guard < 600) begin
      tick();
      guard++;
    end
    chk("midrst.reached500", {32'd0, cnt_a}, 64'd500);
    assert_reset();
    chk("midrst.rst_out_n", {63'd0, rst_a}, 64'd0);
    chk("midrst.run_o", {63'd0, run_a}, 64'd0);
    chk("midrst.cycle_cnt_o", {32'd0, cnt_a}, 64'd0);
    chk("midrst.done_o", {63'd0, done_a}, 64'd0);
    chk("midrst.timeout_o", {63'd0, to_a}, 64'd0);
    chk("midrst.hb_o", {63'd0, hb_a}, 64'd0);
    stop_i = 1'b1;
    repeat (4) tick();
    reset_n = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      if (i == 6) stop_i = 1'b0;
      tick();
      chk($sformatf("midrst.rel@%0d", i), {63'd0, rst_a}, {63'd0, (i == 13)});
    end
    chk("midrst.restart_cnt0", {32'd0, cnt_a}, 64'd0);
    tick();
    chk("midrst.restart_cnt1", {32'd0, cnt_a}, 64'd1);

    // randomized stop pulses and async resets, checked every cycle
    for (int r = 0; r < 12; r++) begin
      int unsigned len;
      assert_reset();
      repeat ($urandom_range(1, 4)) tick();
      reset_n = 1'b1;
      len = $urandom_range(200, 1300);
      for (int unsigned c = 0; c < len; c++) begin
        stop_i = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 599) == 0) begin
          assert_reset();
          repeat ($urandom_range(1, 3)) tick();
          reset_n = 1'b1;
        end
        tick();
      end
      stop_i = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
